// File: rtl/dec_pkg.sv
// Shared types and helpers for decoder BIST sequencing: FSM states, widths and
// the golden one-hot pattern a 4-to-16 decoder must produce.
package dec_pkg;

  localparam int unsigned CodeW = 4;
  localparam int unsigned OutW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  function automatic logic [OutW-1:0] onehot_exp(logic [CodeW-1:0] code);
    logic [OutW-1:0] one;
    one = {{(OutW-1){1'b0}}, 1'b1};
    return one << code;
  endfunction

endpackage

// File: rtl/dec_bist_ctrl_if.sv
// Bundle between the BIST controller (master) and the decoder-under-test
// harness (slave): select code out, decoder outputs back, scan status/results.
interface dec_bist_ctrl_if;
  import dec_pkg::*;

  logic                 start;
  logic                 X;
  logic                 Y;
  logic                 Z;
  logic                 W;
  logic [OutW-1:0]      D;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [OutW-1:0]      fault_map;
  logic [CodeW-1:0]     first_fail;
  logic [CodeW:0]       fail_count;

  modport master (
    input  start, D,
    output X, Y, Z, W, busy, done, pass, fault_map, first_fail, fail_count
  );

  modport slave (
    output start, D,
    input  X, Y, Z, W, busy, done, pass, fault_map, first_fail, fail_count
  );

endinterface

// File: rtl/dec_onehot_chk.sv
// Flags a decoder response that is not exactly the one-hot pattern for code.
module dec_onehot_chk
  import dec_pkg::*;
(
  input  logic [CodeW-1:0] code,
  input  logic [OutW-1:0]  D,
  output logic             err
);

  always_comb begin
    err = (D != onehot_exp(code));
  end

endmodule

// File: rtl/dec_bist_ctrl.sv
// Sequences all 16 select codes into an external 4-to-16 decoder, waits
// SETTLE_CYCLES per code, samples D and accumulates a per-code fault map.
module dec_bist_ctrl
  import dec_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  dec_bist_ctrl_if.master bus
);

  localparam logic [3:0]       SettleInit = 4'(SETTLE_CYCLES);
  localparam state_e           FirstSt    = (SETTLE_CYCLES == 0) ? StSample : StSettle;
  localparam logic [CodeW-1:0] LastCode   = {CodeW{1'b1}};

  state_e           state_q, state_d;
  logic [CodeW-1:0] code_q;
  logic [3:0]       cnt_q;
  logic [OutW-1:0]  fault_map_q;
  logic [CodeW-1:0] first_fail_q;
  logic [CodeW:0]   fail_count_q;
  logic             done_q;
  logic             pass_q;
  logic             err;
  logic             start_ok;

  dec_onehot_chk u_chk (
    .code (code_q),
    .D    (bus.D),
    .err  (err)
  );

  // start is only honoured when no scan is in flight.
  assign start_ok = bus.start && ((state_q == StIdle) || (state_q == StDone));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) state_d = FirstSt;
      end
      StSettle: begin
        if (cnt_q <= 4'd1) state_d = StSample;
      end
      StSample: begin
        state_d = (code_q == LastCode) ? StDone : FirstSt;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q       <= '0;
      cnt_q        <= '0;
      fault_map_q  <= '0;
      first_fail_q <= '0;
      fail_count_q <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_ok) begin
            code_q       <= '0;
            cnt_q        <= SettleInit;
            fault_map_q  <= '0;
            first_fail_q <= '0;
            fail_count_q <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
          end
        end
        StSettle: begin
          cnt_q <= cnt_q - 4'd1;
        end
        StSample: begin
          if (err) begin
            fault_map_q[code_q] <= 1'b1;
            fail_count_q        <= fail_count_q + 1'b1;
            if (fail_count_q == '0) first_fail_q <= code_q;
          end
          if (code_q != LastCode) begin
            code_q <= code_q + 1'b1;
            cnt_q  <= SettleInit;
          end else begin
            done_q <= 1'b1;
            // Fold in the final sample, whose count update lands on this same edge.
            pass_q <= (fail_count_q == '0) && !err;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy       = (state_q == StSettle) || (state_q == StSample);
    bus.X          = code_q[3];
    bus.Y          = code_q[2];
    bus.Z          = code_q[1];
    bus.W          = code_q[0];
    bus.done       = done_q;
    bus.pass       = pass_q;
    bus.fault_map  = fault_map_q;
    bus.first_fail = first_fail_q;
    bus.fail_count = fail_count_q;
  end

endmodule

// File: tb/tb_dec_bist_ctrl.sv
// Bench for dec_bist_ctrl: a fault-injectable decoder model drives D, and each
// scan's timing and results are compared against a per-code reference model.
module tb_dec_bist_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dec_bist_ctrl_if bif2 ();
  dec_bist_ctrl_if bif0 ();

  dec_bist_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bif2));
  dec_bist_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bif0));

  // Index 0 -> SETTLE_CYCLES=2 instance, index 1 -> SETTLE_CYCLES=0 instance.
  logic [15:0] sa0 [2];
  logic [15:0] sa1 [2];
  logic [15:0] flip [2][16];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [15:0] dec_out(int sel, int c);
    logic [15:0] v;
    v = 16'h0001;
    v = v << c;
    return ((v & ~sa0[sel]) | sa1[sel]) ^ flip[sel][c];
  endfunction

  always_comb begin
    bif2.D = dec_out(0, int'({bif2.X, bif2.Y, bif2.Z, bif2.W}));
    bif0.D = dec_out(1, int'({bif0.X, bif0.Y, bif0.Z, bif0.W}));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] code_of(int sel);
    return (sel == 0) ? {bif2.X, bif2.Y, bif2.Z, bif2.W} : {bif0.X, bif0.Y, bif0.Z, bif0.W};
  endfunction
  function automatic logic busy_of(int sel);
    return (sel == 0) ? bif2.busy : bif0.busy;
  endfunction
  function automatic logic done_of(int sel);
    return (sel == 0) ? bif2.done : bif0.done;
  endfunction
  function automatic logic pass_of(int sel);
    return (sel == 0) ? bif2.pass : bif0.pass;
  endfunction
  function automatic logic [15:0] fm_of(int sel);
    return (sel == 0) ? bif2.fault_map : bif0.fault_map;
  endfunction
  function automatic logic [3:0] ff_of(int sel);
    return (sel == 0) ? bif2.first_fail : bif0.first_fail;
  endfunction
  function automatic logic [4:0] fc_of(int sel);
    return (sel == 0) ? bif2.fail_count : bif0.fail_count;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) bif2.start = v;
    else          bif0.start = v;
  endtask

  task automatic clear_faults();
    for (int s = 0; s < 2; s++) begin
      sa0[s] = '0;
      sa1[s] = '0;
      for (int c = 0; c < 16; c++) flip[s][c] = '0;
    end
  endtask

  // Expected scan results: walk every code and judge the decoder response.
  task automatic ref_model(input int sel, output logic [15:0] fm, output int ff,
                           output int fc);
    logic [15:0] want;
    fm = '0;
    ff = 0;
    fc = 0;
    for (int i = 0; i < 16; i++) begin
      want = 16'h0001;
      want = want << i;
      if (dec_out(sel, i) != want) begin
        fm[i] = 1'b1;
        if (fc == 0) ff = i;
        fc++;
      end
    end
  endtask

  task automatic check_reset_vals(input int sel, input string tag);
    check({tag, "_code"}, 32'(code_of(sel)), 0);
    check({tag, "_busy"}, 32'(busy_of(sel)), 0);
    check({tag, "_done"}, 32'(done_of(sel)), 0);
    check({tag, "_pass"}, 32'(pass_of(sel)), 0);
    check({tag, "_fm"},   32'(fm_of(sel)),   0);
    check({tag, "_ff"},   32'(ff_of(sel)),   0);
    check({tag, "_fc"},   32'(fc_of(sel)),   0);
  endtask

  // One full scan; optionally re-pulse start at relative cycle restart_at.
  task automatic scan(input int sel, input int restart_at, input string tag);
    int spc, total, eff, efc;
    logic [15:0] efm;
    spc   = (sel == 0) ? 3 : 1;
    total = 16 * spc;
    ref_model(sel, efm, eff, efc);
    @(negedge clk);
    set_start(sel, 1'b1);
    for (int m = 0; m <= total; m++) begin
      @(negedge clk);
      set_start(sel, 1'b0);
      if (m < total) begin
        check({tag, "_code"}, 32'(code_of(sel)), 32'(m / spc));
        check({tag, "_busy"}, 32'(busy_of(sel)), 1);
        check({tag, "_done_early"}, 32'(done_of(sel)), 0);
        if (m == restart_at) set_start(sel, 1'b1);
      end else begin
        check({tag, "_done"}, 32'(done_of(sel)), 1);
        check({tag, "_busy_end"}, 32'(busy_of(sel)), 0);
        check({tag, "_code_end"}, 32'(code_of(sel)), 15);
      end
    end
    check({tag, "_fm"},   32'(fm_of(sel)), 32'(efm));
    check({tag, "_ff"},   32'(ff_of(sel)), 32'(eff));
    check({tag, "_fc"},   32'(fc_of(sel)), 32'(efc));
    check({tag, "_pass"}, 32'(pass_of(sel)), 32'(efc == 0));
    repeat (3) @(negedge clk);
    check({tag, "_done_hold"}, 32'(done_of(sel)), 1);
    check({tag, "_pass_hold"}, 32'(pass_of(sel)), 32'(efc == 0));
    check({tag, "_fm_hold"},   32'(fm_of(sel)), 32'(efm));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bif2.start = 1'b0;
    bif0.start = 1'b0;
    clear_faults();
    repeat (3) @(negedge clk);
    check_reset_vals(0, "rst2");
    check_reset_vals(1, "rst0");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    scan(0, -1, "clean2");

    sa0[0] = 16'h0008;
    scan(0, -1, "sa0_d3");
    check("sa0_d3_fm_const", 32'(fm_of(0)), 32'h0008);
    check("sa0_d3_ff_const", 32'(ff_of(0)), 3);
    check("sa0_d3_fc_const", 32'(fc_of(0)), 1);
    clear_faults();

    sa1[0] = 16'h0020;
    scan(0, -1, "sa1_d5");
    check("sa1_d5_fm_const", 32'(fm_of(0)), 32'hFFDF);
    check("sa1_d5_ff_const", 32'(ff_of(0)), 0);
    check("sa1_d5_fc_const", 32'(fc_of(0)), 15);
    clear_faults();

    // Re-pulse while code 6 is applied (cycles 18..20 of the scan).
    scan(0, 19, "busy_start");

    for (int r = 0; r < 6; r++) begin
      clear_faults();
      for (int s = 0; s < 2; s++) begin
        for (int c = 0; c < 16; c++)
          if ($urandom_range(0, 3) == 0) flip[s][c] = 16'($urandom_range(1, 65535));
        if ($urandom_range(0, 2) == 0) sa0[s] = 16'h0001 << $urandom_range(0, 15);
        if ($urandom_range(0, 2) == 0) sa1[s] = 16'h0001 << $urandom_range(0, 15);
      end
      scan(0, -1, $sformatf("rand2_%0d", r));
      scan(1, -1, $sformatf("rand0_%0d", r));
    end
    clear_faults();

    // Reset mid-scan at code 7 with a partial result already recorded.
    flip[0][2] = 16'h0100;
    @(negedge clk);
    bif2.start = 1'b1;
    @(negedge clk);
    bif2.start = 1'b0;
    begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
        if (code_of(0) == 4'd7) found = 1'b1;
        else @(negedge clk);
      end
      check("reach_code7", 32'(found), 1);
    end
    check("live_fm", 32'(fm_of(0)), 32'h0004);
    check("live_fc", 32'(fc_of(0)), 1);
    #1 rst = 1'b1;
    #1;
    check_reset_vals(0, "midrst");
    @(negedge clk);
    rst = 1'b0;
    scan(0, -1, "after_rst");
    clear_faults();

    scan(1, -1, "clean0");
    scan(0, -1, "clean2_again");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
